fft_frame_src: RTL and testbench

FFT_FRAME_SRC -- requirements
Module: fft_frame_src

---
 rtl/fft_frame_src_if.sv | 35 +++
 rtl/fft_frame_src.sv | 186 ++++++++++++++++++
 tb/tb_fft_frame_src.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_src_if.sv
//------------------------------------------------------------------------------
// fft_frame_src_if
//   Streaming sample interface between the frame source and an FFT core.
//   A sample moves on every cycle where sink_valid and sink_ready are both high.
//
//   sink_valid  source -> core   sink_real/sink_imag hold a valid sample
//   sink_ready  core -> source   core accepts a sample this cycle
//   sink_sop    source -> core   first sample of a frame (qualified by valid)
//   sink_eop    source -> core   last sample of a frame (qualified by valid)
//   sink_real   source -> core   real part, DW bits two's complement
//   sink_imag   source -> core   imaginary part, DW bits two's complement
//
//   modport master : the sample source (fft_frame_src)
//   modport slave  : the FFT core
//------------------------------------------------------------------------------
interface fft_frame_src_if #(
   parameter int DW = 16
);
   logic          sink_valid;
   logic          sink_ready;
   logic          sink_sop;
   logic          sink_eop;
   logic [DW-1:0] sink_real;
   logic [DW-1:0] sink_imag;

   modport master (
      output sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
      input  sink_ready
   );

   modport slave (
      input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
      output sink_ready
   );
endinterface

// File: rtl/fft_frame_src.sv
//------------------------------------------------------------------------------
// fft_frame_src
//   Collects ADC samples into a two-bank ping-pong buffer of NFFT words per
//   bank and streams each full bank to an FFT core as one framed burst
//   (sop on word 0, eop on word NFFT-1) at up to one word per clock.
//
// Parameters
//   NFFT  samples per frame, power of two, 8..4096
//   DW    sample width, two's complement
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset; aborts any frame in flight
//   adc_data   input sample
//   adc_valid  adc_data valid this cycle
//   sink       fft_frame_src_if.master, stream to the FFT core
//   frame_cnt  frames fully transferred, wraps at 65535
//   overflow   sticky: a sample arrived while both banks were full
//
// Build option
//   FFT_SRC_SIGNFLIP_EN  when defined, odd-indexed words are negated on
//                        sink_real ((-1)^n modulation, DC moved to the centre
//                        bin); the most negative value saturates to the most
//                        positive one.
//------------------------------------------------------------------------------
module fft_frame_src #(
   parameter int NFFT = 512,
   parameter int DW   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DW-1:0]          adc_data,
   input  logic                   adc_valid,
   fft_frame_src_if.master        sink,
   output logic [15:0]            frame_cnt,
   output logic                   overflow
);

   localparam int AW = $clog2(NFFT);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM
   } state_t;

   logic [DW-1:0] mem [2*NFFT];

   state_t        state;
   logic          wr_bank;
   logic [AW-1:0] wr_idx;
   logic          rd_bank;
   logic [AW-1:0] rd_idx;
   logic [1:0]    full;

   logic          valid_q;
   logic          sop_q;
   logic          eop_q;
   logic [DW-1:0] real_q;

   logic          wr_fire;
   logic          rd_xfer;
   logic          rd_done;
   logic [DW-1:0] rd_raw;
   logic [DW-1:0] rd_word;

   // The writer only ever targets a bank that is not full and the reader only
   // a bank that is, so the two never touch the same bank in one cycle.
   assign wr_fire = adc_valid && !full[wr_bank];
   assign rd_xfer = valid_q && sink.sink_ready;
   assign rd_done = (state == STREAM) && rd_xfer && eop_q;

   // rd_idx always points at the word the output register will load next:
   // word 0 while in LOAD, the following word while in STREAM.
   assign rd_raw = mem[{rd_bank, rd_idx}];

`ifdef FFT_SRC_SIGNFLIP_EN
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

   // -MOST_NEG does not fit in DW bits, so it clamps to MOST_POS.
   assign rd_word = !rd_idx[0]          ? rd_raw   :
                    (rd_raw == MOST_NEG) ? MOST_POS : -rd_raw;
`else
   assign rd_word = rd_raw;
`endif

   // NOTE: the sample store has no reset; emptiness is tracked by the full
   // flags, so stale contents are never read and the array can map to RAM.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[{wr_bank, wr_idx}] <= adc_data;
      end
   end

   // Write side and bank bookkeeping. A bank is set full by the writer and
   // freed by the reader; since they always address different banks, a
   // completion on both sides in one cycle updates both flags independently.
   // NOTE: all state here uses non-blocking assignments so every read in the
   // block sees the pre-edge value, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 2'b00;
         wr_bank  <= 1'b0;
         wr_idx   <= '0;
         overflow <= 1'b0;
      end else begin
         if (adc_valid && full[wr_bank]) begin
            overflow <= 1'b1;
         end
         if (wr_fire) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == AW'(NFFT - 1)) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end
         end
         if (rd_done) begin
            full[rd_bank] <= 1'b0;
         end
      end
   end

   // Reader FSM. The output register is the memory read register: LOAD
   // fetches word 0, and each STREAM transfer fetches the following word in
   // the same edge, giving one word per clock without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_bank   <= 1'b0;
         rd_idx    <= '0;
         valid_q   <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         real_q    <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (full[rd_bank]) begin
                  state <= LOAD;
               end
            end

            LOAD: begin
               real_q  <= rd_word;
               valid_q <= 1'b1;
               sop_q   <= 1'b1;
               eop_q   <= 1'b0;
               rd_idx  <= rd_idx + 1'b1;
               state   <= STREAM;
            end

            STREAM: begin
               if (rd_xfer) begin
                  if (eop_q) begin
                     valid_q   <= 1'b0;
                     sop_q     <= 1'b0;
                     eop_q     <= 1'b0;
                     rd_idx    <= '0;
                     rd_bank   <= ~rd_bank;
                     frame_cnt <= frame_cnt + 16'd1;
                     // The flag of the other bank is the pre-edge value; a bank
                     // filling on this very edge is picked up from IDLE instead.
                     state     <= full[~rd_bank] ? LOAD : IDLE;
                  end else begin
                     real_q <= rd_word;
                     sop_q  <= 1'b0;
                     eop_q  <= (rd_idx == AW'(NFFT - 1));
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign sink.sink_valid = valid_q;
   assign sink.sink_sop   = sop_q;
   assign sink.sink_eop   = eop_q;
   assign sink.sink_real  = real_q;
   assign sink.sink_imag  = '0;

endmodule

// File: tb/tb_fft_frame_src.sv
//------------------------------------------------------------------------------
// tb_fft_frame_src
//   Directed bench for fft_frame_src with NFFT=512, DW=16. Inputs are driven
//   1 time unit after each rising edge; outputs are sampled at the same point,
//   so a transfer is recorded when sink_valid is seen high and sink_ready is
//   driven high for the coming edge.
//------------------------------------------------------------------------------
module tb_fft_frame_src;

   localparam int NFFT = 512;
   localparam int DW   = 16;

`ifdef FFT_SRC_SIGNFLIP_EN
   localparam bit FLIP = 1'b1;
`else
   localparam bit FLIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] adc_data;
   logic          adc_valid;
   logic [15:0]   frame_cnt;
   logic          overflow;

   fft_frame_src_if #(.DW(DW)) snk ();

   fft_frame_src #(
      .NFFT (NFFT),
      .DW   (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .adc_data  (adc_data),
      .adc_valid (adc_valid),
      .sink      (snk),
      .frame_cnt (frame_cnt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected sink_real for input value v; negate_it selects the odd-word
   // sign flip of the optional build, saturating the most negative value.
   function automatic logic [DW-1:0] exp_word(input int v, input bit negate_it);
      logic [DW-1:0] w;
      w = DW'(v);
      if (negate_it) begin
         w = (w == 16'h8000) ? 16'h7fff : -w;
      end
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      adc_valid      = 1'b0;
      adc_data       = '0;
      snk.sink_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Feeds feed_n ramp samples base, base+1, ... and accepts every word with
   // sink_ready high until want transfers have been seen. Every transfer i
   // must carry base+i with sop/eop on the frame boundaries.
   task automatic run_stream(input int base, input int feed_n, input int want,
                             output int got, output int bad, output int first_vld,
                             output int sop0_cyc, output int eop0_cyc);
      int k_in;
      k_in      = 0;
      got       = 0;
      bad       = 0;
      first_vld = -1;
      sop0_cyc  = -1;
      eop0_cyc  = -1;
      for (int cyc = 0; cyc < 4 * want + 64 && got < want; cyc++) begin
         step();
         if (snk.sink_valid && first_vld < 0) first_vld = cyc;
         adc_valid = (k_in < feed_n);
         adc_data  = DW'(base + k_in);
         if (k_in < feed_n) k_in++;
         snk.sink_ready = 1'b1;
         if (snk.sink_valid) begin
            if (snk.sink_real !== exp_word(base + got, FLIP && (got % 2 == 1))) bad++;
            if (snk.sink_sop !== (got % NFFT == 0)) bad++;
            if (snk.sink_eop !== (got % NFFT == NFFT - 1)) bad++;
            if (got == 0) sop0_cyc = cyc;
            if (got == NFFT - 1) eop0_cyc = cyc;
            got++;
         end
      end
      adc_valid = 1'b0;
   endtask

   initial begin
      int got, bad, first_vld, sop0_cyc, eop0_cyc;
      int k_in, stall, stalled, held_bad, idle_bad;
      logic [DW-1:0] w1, w257;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_valid", snk.sink_valid, 0);
      check("rst_sop", snk.sink_sop, 0);
      check("rst_eop", snk.sink_eop, 0);
      check("rst_real", snk.sink_real, 0);
      check("rst_imag", snk.sink_imag, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_overflow", overflow, 0);

      // ---------------- continuous ramp 0..1023, two frames ----------------
      run_stream(0, 2 * NFFT, 2 * NFFT, got, bad, first_vld, sop0_cyc, eop0_cyc);
      check("ramp_count", got, 2 * NFFT);
      check("ramp_words", bad, 0);
      // Sample 511 is driven in iteration 511 and written at the next edge;
      // sink_valid rises two edges after that write.
      check("first_valid_latency", first_vld, NFFT + 2);
      check("frame0_no_bubbles", eop0_cyc - sop0_cyc, NFFT - 1);
      step();
      check("ramp_frame_cnt", frame_cnt, 2);
      check("ramp_overflow", overflow, 0);
      check("ramp_valid_after", snk.sink_valid, 0);
      check("ramp_imag", snk.sink_imag, 0);

      // ---------------- back-pressure at word 100 ----------------
      do_reset();
      k_in = 0; got = 0; bad = 0; stall = 0; stalled = 0; held_bad = 0;
      for (int cyc = 0; cyc < 3000 && got < NFFT; cyc++) begin
         step();
         adc_valid = (k_in < NFFT);
         adc_data  = DW'(2000 + k_in);
         if (k_in < NFFT) k_in++;
         if (snk.sink_valid && got == 100 && stalled == 0) begin
            stall   = 5;
            stalled = 1;
         end
         if (stall > 0) begin
            snk.sink_ready = 1'b0;
            stall--;
            if (!snk.sink_valid) held_bad++;
            if (snk.sink_real !== exp_word(2100, FLIP && 1'b0)) held_bad++;
            if (snk.sink_sop || snk.sink_eop) held_bad++;
         end else begin
            snk.sink_ready = 1'b1;
         end
         if (snk.sink_valid && snk.sink_ready) begin
            if (snk.sink_real !== exp_word(2000 + got, FLIP && (got % 2 == 1))) bad++;
            if (snk.sink_sop !== (got == 0)) bad++;
            if (snk.sink_eop !== (got == NFFT - 1)) bad++;
            got++;
         end
      end
      adc_valid = 1'b0;
      check("stall_seen", stalled, 1);
      check("stall_hold", held_bad, 0);
      check("stall_count", got, NFFT);
      check("stall_words", bad, 0);
      step();
      check("stall_frame_cnt", frame_cnt, 1);

      // ---------------- both banks full, drop, then reset mid-frame ----------------
      do_reset();
      for (int k = 0; k <= 2 * NFFT; k++) begin
         step();
         if (k == 2 * NFFT) check("ovf_before_drop", overflow, 0);
         adc_valid = 1'b1;
         adc_data  = DW'(k);
      end
      step();
      adc_valid = 1'b0;
      step();
      check("ovf_set", overflow, 1);
      check("ovf_valid_held", snk.sink_valid, 1);
      check("ovf_sop_held", snk.sink_sop, 1);
      check("ovf_word0_held", snk.sink_real, exp_word(0, 1'b0));
      // Drain frame 0 and 300 words of frame 1; sample 1024 must be absent.
      run_stream(0, 0, NFFT + 300, got, bad, first_vld, sop0_cyc, eop0_cyc);
      check("drain_count", got, NFFT + 300);
      check("drain_words", bad, 0);
      check("drain_frame_cnt", frame_cnt, 1);
      rst = 1'b1;
      step();
      check("midrst_valid", snk.sink_valid, 0);
      check("midrst_eop", snk.sink_eop, 0);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_overflow", overflow, 0);
      rst = 1'b0;
      idle_bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (snk.sink_valid) idle_bad++;
      end
      check("midrst_discarded", idle_bad, 0);
      run_stream(5000, NFFT, NFFT, got, bad, first_vld, sop0_cyc, eop0_cyc);
      check("fresh_count", got, NFFT);
      check("fresh_words", bad, 0);
      check("fresh_latency", first_vld, NFFT + 2);
      step();
      check("fresh_frame_cnt", frame_cnt, 1);

      // ---------------- constant 1000, then most negative value ----------------
      do_reset();
      k_in = 0; got = 0; bad = 0; w1 = '0; w257 = '0;
      for (int cyc = 0; cyc < 3000 && got < NFFT; cyc++) begin
         step();
         adc_valid = (k_in < NFFT);
         adc_data  = (k_in < 256) ? 16'd1000 : 16'h8000;
         if (k_in < NFFT) k_in++;
         snk.sink_ready = 1'b1;
         if (snk.sink_valid) begin
            if (snk.sink_real !== exp_word((got < 256) ? 1000 : -32768, FLIP && (got % 2 == 1))) bad++;
            if (got == 1) w1 = snk.sink_real;
            if (got == 257) w257 = snk.sink_real;
            got++;
         end
      end
      adc_valid = 1'b0;
      check("const_count", got, NFFT);
      check("const_words", bad, 0);
      check("const_word1", w1, FLIP ? 16'hfc18 : 16'd1000);
      check("const_word257", w257, FLIP ? 16'h7fff : 16'h8000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
